// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter and access sequencer in front of the Bridge.
// Master 0 is the CPU data port, master 1 a secondary master (DMA / loader).
// Each access holds the Bus for WAIT_CYC cycles (1..15), then acks for one cycle.
// Build option: define BUS_ARB_FIXED_PRIO_EN to give master 0 fixed priority
// on simultaneous requests (no last-served pointer; master 1 can starve).
// Without it, ties are resolved round-robin.
module bus_arbiter #(
    parameter int WAIT_CYC = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        cpu_stall,
    output logic [31:0] Bus_addr,
    output logic        Bus_wen,
    output logic [31:0] Bus_wdata,
    input  logic [31:0] Bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // cnt counts down from CNT_LOAD, so the first ACCESS cycle is cnt == CNT_LOAD
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        winner;     // 0: master 0, 1: master 1
    logic        grant;      // arbitration result for the current IDLE cycle
    logic [31:0] lat_addr;
    logic        lat_wen;
    logic [31:0] lat_wdata;
    logic        access_done;

    assign access_done = (state == ACCESS) && (cnt == 4'd0);

`ifdef BUS_ARB_FIXED_PRIO_EN
    // Fixed priority: master 0 wins whenever it requests
    always_comb begin
        grant = m0_req ? 1'b0 : 1'b1;
    end
`else
    logic last;

    // Round-robin: on a tie the master that was not served last wins
    always_comb begin
        if (m0_req && m1_req) begin
            grant = ~last;
        end else begin
            grant = m0_req ? 1'b0 : 1'b1;
        end
    end

    // Last-served pointer; resets to 1 so master 0 wins the first tie
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            last <= 1'b1;
        end else if (access_done) begin
            last <= winner;
        end
    end
`endif

    // State register
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one access per IDLE -> ACCESS -> ACK round
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (m0_req || m1_req) state_next = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning request on entry to ACCESS and pace the access with cnt
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            cnt       <= 4'd0;
            winner    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wen   <= 1'b0;
            lat_wdata <= 32'd0;
        end else if (state == IDLE) begin
            if (m0_req || m1_req) begin
                winner    <= grant;
                lat_addr  <= grant ? m1_addr  : m0_addr;
                lat_wen   <= grant ? m1_wen   : m0_wen;
                lat_wdata <= grant ? m1_wdata : m0_wdata;
                cnt       <= CNT_LOAD;
            end
        end else if ((state == ACCESS) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Capture read data into the winner's register on the last ACCESS cycle
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            m0_rdata <= 32'd0;
            m1_rdata <= 32'd0;
        end else if (access_done && !lat_wen) begin
            if (winner) begin
                m1_rdata <= Bus_rdata;
            end else begin
                m0_rdata <= Bus_rdata;
            end
        end
    end

    // Bus drive and ack decode; write enable only on the first ACCESS cycle
    always_comb begin
        Bus_addr  = 32'd0;
        Bus_wdata = 32'd0;
        Bus_wen   = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        if (state == ACCESS) begin
            Bus_addr  = lat_addr;
            Bus_wdata = lat_wdata;
            Bus_wen   = lat_wen && (cnt == CNT_LOAD);
        end else if (state == ACK) begin
            m0_ack = ~winner;
            m1_ack = winner;
        end
    end

    assign cpu_stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: two arbiter instances (WAIT_CYC=1 and WAIT_CYC=3) driven by
// directed sequences and then randomized master traffic, compared every cycle
// against a transaction-timeline model of the arbiter.
module tb_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rq     [2][2];
    logic [31:0] ad     [2][2];
    logic        wn     [2][2];
    logic [31:0] wd     [2][2];
    logic        ak     [2][2];
    logic [31:0] rd     [2][2];
    logic        stall  [2];
    logic [31:0] baddr  [2];
    logic        bwen   [2];
    logic [31:0] bwdata [2];
    logic [31:0] brdata [2];

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    // Bridge stand-in: read data is a fixed function of the address
    function automatic logic [31:0] bridge(input logic [31:0] a);
        if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic int wc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign brdata[g] = bridge(baddr[g]);
        bus_arbiter #(.WAIT_CYC(g == 0 ? 1 : 3)) u_dut (
            .cpu_clk   (clk),
            .cpu_rst   (rst),
            .m0_req    (rq[g][0]),
            .m0_addr   (ad[g][0]),
            .m0_wen    (wn[g][0]),
            .m0_wdata  (wd[g][0]),
            .m0_ack    (ak[g][0]),
            .m0_rdata  (rd[g][0]),
            .m1_req    (rq[g][1]),
            .m1_addr   (ad[g][1]),
            .m1_wen    (wn[g][1]),
            .m1_wdata  (wd[g][1]),
            .m1_ack    (ak[g][1]),
            .m1_rdata  (rd[g][1]),
            .cpu_stall (stall[g]),
            .Bus_addr  (baddr[g]),
            .Bus_wen   (bwen[g]),
            .Bus_wdata (bwdata[g]),
            .Bus_rdata (brdata[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is granted at the end of an idle cycle; k counts cycles since
    // the grant: k=1..W the Bus carries it, k=W+1 is the ack, then idle again.
    bit          act   [2] = '{1'b0, 1'b0};
    int          k     [2] = '{0, 0};
    bit          win   [2] = '{1'b0, 1'b0};
    bit          lastm [2] = '{1'b1, 1'b1};
    logic [31:0] maddr [2];
    bit          mwen  [2];
    logic [31:0] mwdat [2];
    logic [31:0] erd   [2][2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                act[i]    = 1'b0;
                k[i]      = 0;
                lastm[i]  = 1'b1;
                erd[i][0] = 32'd0;
                erd[i][1] = 32'd0;
            end else if (act[i]) begin
                if (k[i] == wc(i)) begin
                    if (!mwen[i]) erd[i][win[i]] = bridge(maddr[i]);
                    lastm[i] = win[i];
                end
                if (k[i] == wc(i) + 1) act[i] = 1'b0;
                else k[i] = k[i] + 1;
            end else if (rq[i][0] || rq[i][1]) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
                win[i] = rq[i][0] ? 1'b0 : 1'b1;
`else
                win[i] = (rq[i][0] && rq[i][1]) ? ~lastm[i] : (rq[i][0] ? 1'b0 : 1'b1);
`endif
                maddr[i] = ad[i][win[i]];
                mwen[i]  = wn[i][win[i]];
                mwdat[i] = wd[i][win[i]];
                act[i]   = 1'b1;
                k[i]     = 1;
            end
        end
    end

    function automatic bit in_acc(input int i);
        return act[i] && (k[i] >= 1) && (k[i] <= wc(i));
    endfunction

    function automatic bit exp_ack(input int i, input int m);
        return act[i] && (k[i] == wc(i) + 1) && (int'(win[i]) == m);
    endfunction

    // Per-cycle comparison of both instances against the model
    always begin
        @(negedge clk);
        #2;
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("i%0d_bus_addr", i), baddr[i], in_acc(i) ? maddr[i] : 32'd0);
                chk($sformatf("i%0d_bus_wdata", i), bwdata[i], in_acc(i) ? mwdat[i] : 32'd0);
                chk($sformatf("i%0d_bus_wen", i), 32'(bwen[i]), 32'(in_acc(i) && (k[i] == 1) && mwen[i]));
                chk($sformatf("i%0d_m0_ack", i), 32'(ak[i][0]), 32'(exp_ack(i, 0)));
                chk($sformatf("i%0d_m1_ack", i), 32'(ak[i][1]), 32'(exp_ack(i, 1)));
                chk($sformatf("i%0d_m0_rdata", i), rd[i][0], erd[i][0]);
                chk($sformatf("i%0d_m1_rdata", i), rd[i][1], erd[i][1]);
                chk($sformatf("i%0d_stall", i), 32'(stall[i]), 32'(rq[i][0] && !exp_ack(i, 0)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 2; m++) rq[i][m] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait up to lim cycles for an ack; n = cycles waited, -1 if none
    task automatic wait_ack(input int i, input int m, input int lim, output int n);
        n = -1;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            #1;
            if (ak[i][m]) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic new_fields(input int i, input int m);
        ad[i][m] = $urandom;
        wn[i][m] = 1'($urandom_range(0, 1));
        wd[i][m] = $urandom;
    endtask

    task automatic rand_step();
        rst = ($urandom_range(0, 99) == 0);
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (rst) begin
                    rq[i][m] = 1'b0;
                end else if (rq[i][m]) begin
                    if (ak[i][m]) begin
                        if ($urandom_range(0, 1) == 1) new_fields(i, m);
                        else rq[i][m] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rq[i][m] = 1'b1;
                    new_fields(i, m);
                end
            end
        end
    endtask

    initial begin
        int n;
        int got;
        int seq_m [4];
        int seq_c [4];

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                rq[i][m] = 1'b0;
                ad[i][m] = 32'd0;
                wn[i][m] = 1'b0;
                wd[i][m] = 32'd0;
            end
        end
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        #1;
        chk("rst_bus_addr", baddr[0], 32'd0);
        chk("rst_bus_wen", 32'(bwen[0]), 32'd0);
        chk("rst_m0_ack", 32'(ak[0][0]), 32'd0);
        chk("rst_m0_rdata", rd[0][0], 32'd0);
        chk("rst_stall", 32'(stall[0]), 32'd0);
        rst = 1'b0;

        // Single read on WAIT_CYC=1
        @(negedge clk);
        rq[0][0] = 1'b1; ad[0][0] = 32'h8000_0010; wn[0][0] = 1'b0;
        #1;
        chk("rd_stall_t0", 32'(stall[0]), 32'd1);
        @(negedge clk); #1;
        chk("rd_stall_t1", 32'(stall[0]), 32'd1);
        chk("rd_addr_t1", baddr[0], 32'h8000_0010);
        chk("rd_ack_t1", 32'(ak[0][0]), 32'd0);
        @(negedge clk); #1;
        chk("rd_ack_t2", 32'(ak[0][0]), 32'd1);
        chk("rd_data_t2", rd[0][0], 32'hDEAD_BEEF);
        chk("rd_stall_t2", 32'(stall[0]), 32'd0);
        rq[0][0] = 1'b0;
        @(negedge clk); #1;
        chk("rd_ack_t3", 32'(ak[0][0]), 32'd0);
        chk("rd_data_hold", rd[0][0], 32'hDEAD_BEEF);

        // Single write on WAIT_CYC=3
        @(negedge clk);
        rq[1][1] = 1'b1; ad[1][1] = 32'h8000_0020; wn[1][1] = 1'b1; wd[1][1] = 32'h1234_5678;
        #1;
        chk("wr_wen_t0", 32'(bwen[1]), 32'd0);
        @(negedge clk); #1;
        chk("wr_wen_t1", 32'(bwen[1]), 32'd1);
        chk("wr_addr_t1", baddr[1], 32'h8000_0020);
        chk("wr_wdata_t1", bwdata[1], 32'h1234_5678);
        @(negedge clk); #1;
        chk("wr_wen_t2", 32'(bwen[1]), 32'd0);
        chk("wr_addr_t2", baddr[1], 32'h8000_0020);
        @(negedge clk); #1;
        chk("wr_addr_t3", baddr[1], 32'h8000_0020);
        chk("wr_ack_t3", 32'(ak[1][1]), 32'd0);
        @(negedge clk); #1;
        chk("wr_ack_t4", 32'(ak[1][1]), 32'd1);
        chk("wr_addr_t4", baddr[1], 32'd0);
        chk("wr_rdata_kept", rd[1][1], 32'd0);
        rq[1][1] = 1'b0;

        // Simultaneous continuous requests after reset
        do_reset();
        @(negedge clk);
        rq[0][0] = 1'b1; ad[0][0] = 32'h0000_0100; wn[0][0] = 1'b0;
        rq[0][1] = 1'b1; ad[0][1] = 32'h0000_0200; wn[0][1] = 1'b0;
        got = 0;
        for (int c = 1; c <= 30 && got < 4; c++) begin
            @(negedge clk); #1;
            if (ak[0][0] || ak[0][1]) begin
                seq_m[got] = ak[0][1] ? 1 : 0;
                seq_c[got] = c;
                got++;
            end
        end
        chk("tie_ack_count", got, 4);
        if (got > 0) chk("tie_first_cycle", seq_c[0], 2);
        for (int j = 0; j < got; j++) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
            chk($sformatf("tie_who_%0d", j), seq_m[j], 0);
`else
            chk($sformatf("tie_who_%0d", j), seq_m[j], j % 2);
`endif
            if (j > 0) chk($sformatf("tie_gap_%0d", j), seq_c[j] - seq_c[j-1], 3);
        end
        rq[0][0] = 1'b0; rq[0][1] = 1'b0;

        // Reset during ACCESS of a write (WAIT_CYC=3)
        do_reset();
        @(negedge clk);
        rq[1][0] = 1'b1; ad[1][0] = 32'h8000_0040; wn[1][0] = 1'b1; wd[1][0] = 32'hCAFE_F00D;
        @(negedge clk); #1;
        chk("rstw_wen_t1", 32'(bwen[1]), 32'd1);
        @(negedge clk);
        rst = 1'b1; rq[1][0] = 1'b0;
        #1;
        chk("rstw_addr_t2", baddr[1], 32'h8000_0040);
        @(negedge clk); #1;
        chk("rstw_m0_ack", 32'(ak[1][0]), 32'd0);
        chk("rstw_m1_ack", 32'(ak[1][1]), 32'd0);
        chk("rstw_addr", baddr[1], 32'd0);
        chk("rstw_wen", 32'(bwen[1]), 32'd0);
        chk("rstw_wdata", bwdata[1], 32'd0);
        chk("rstw_rdata", rd[1][0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rq[1][0] = 1'b1; ad[1][0] = 32'h8000_0010; wn[1][0] = 1'b0;
        wait_ack(1, 0, 12, n);
        chk("rstw_after_lat", n, 4);
        chk("rstw_after_data", rd[1][0], 32'hDEAD_BEEF);
        rq[1][0] = 1'b0;

        // Back-to-back reads with req held through ack (WAIT_CYC=1)
        @(negedge clk);
        rq[0][0] = 1'b1; ad[0][0] = 32'h0000_1000; wn[0][0] = 1'b0;
        wait_ack(0, 0, 10, n);
        chk("b2b_lat1", n, 2);
        chk("b2b_data1", rd[0][0], 32'h1000_FFFF);
        ad[0][0] = 32'h0000_2004;
        wait_ack(0, 0, 10, n);
        chk("b2b_gap", n, 3);
        chk("b2b_data2", rd[0][0], 32'h2004_FFFF);
        rq[0][0] = 1'b0;

        // Randomized traffic on both instances, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rand_step();
        end
        @(negedge clk);
        rst = 1'b0;
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and access sequencer between the data-side masters and the Bridge. Master 0 is the CPU data port; master 1 is a secondary master (DMA / program loader). The block picks one request, drives the shared Bus for a fixed number of wait cycles, captures read data and returns a one-cycle acknowledge. It also produces the CPU stall signal used while the CPU's own access is pending or waiting.

## Interface
- `WAIT_CYC`, default 1: Bus hold cycles per access, legal range 1..15.
- `cpu_clk` in 1: single clock; all state changes on the rising edge.
- `cpu_rst` in 1: reset, synchronous, active-high.
- `m0_req`, `m1_req` in 1: access request; held high until the matching ack.
- `m0_addr`, `m1_addr` in 32: byte address; held stable while req is high.
- `m0_wen`, `m1_wen` in 1: 1 for write, 0 for read.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out 32: read data, registered and valid from the ack cycle until the next ack to that master.
- `cpu_stall` out 1: `m0_req & ~m0_ack`, combinational.
- `Bus_addr` out 32: address to the Bridge.
- `Bus_wen` out 1: write enable to the Bridge.
- `Bus_wdata` out 32: write data to the Bridge.
- `Bus_rdata` in 32: read data from the Bridge, valid combinationally for the current `Bus_addr`.

## Operation
- The state machine has three states:
  - IDLE: if no request, stay in IDLE. If any request, arbitrate; latch the winner id, addr, wen and wdata; load `cnt=WAIT_CYC-1`; go to ACCESS.
  - ACCESS: drive the Bus from the latched values. If `cnt!=0`, decrement `cnt`. If `cnt==0`, capture `Bus_rdata` into the winner's rdata register (reads only), update the last-served pointer, and go to ACK.
  - ACK: pulse the winner's ack, then go to IDLE unconditionally. A req that is still high in ACK is treated as a new request in the following IDLE.
- Arbitration is round-robin. A `last` register (1 bit) records the last-served master.
  - If both masters request, the master other than `last` wins.
  - If only one master requests, it wins and `last` is irrelevant.
- `Bus_wen` is high only in the first ACCESS cycle of a write. This prevents repeated writes to peripherals with side effects.
- `Bus_addr` and `Bus_wdata` hold the latched values for all ACCESS cycles. They are 0 in IDLE and ACK.
- On a write, the rdata registers are untouched.
- The block does not decode addresses; the Bridge owns decoding.
- `cnt` is 4 bits wide and cannot wrap because it is reloaded on every IDLE→ACCESS transition.

## Timing
- Reset values: state=IDLE, `last`=1 (so master 0 wins the first tie), `cnt`=0, both acks 0, both rdata registers 0, `Bus_addr`/`Bus_wdata`/`Bus_wen` 0. `cpu_stall` follows `m0_req`.
- Latency runs from the cycle req is sampled high in IDLE to the ack pulse: `WAIT_CYC+1` cycles. With `WAIT_CYC=1`: req at T, ACCESS at T+1, ack at T+2.
- Throughput is one access per `WAIT_CYC+2` cycles; there is no back-to-back ACCESS.
- Simultaneous requests: the loser waits in IDLE-pending and is served in the very next arbitration. It is never starved for more than one access.
- A req dropped before ack is a protocol violation. The block completes the latched access anyway and still pulses ack.
- Reset mid-ACCESS or mid-ACK: the transfer is aborted with no ack. `Bus_wen` is 0 in the cycle after reset is sampled.

## Configuration
- `BUS_ARB_FIXED_PRIO_EN` defined: master 0 always wins simultaneous requests. The `last` register is removed and master 1 can starve.
- Not defined: round-robin as described above.

## Test plan
- Single read: m0 reads addr 0x8000_0010 while the Bridge returns 0xDEAD_BEEF. Required: m0_ack at T+2, m0_rdata=0xDEAD_BEEF, cpu_stall high during T..T+1 and low at T+2.
- Single write, `WAIT_CYC=3`: m1 writes 0x1234_5678 to 0x8000_0020. Required: Bus_wen high for exactly one cycle (T+1); Bus_addr held for T+1..T+3; m1_ack at T+4.
- Simultaneous requests after reset: both masters request continuously. Required: acks alternate m0, m1, m0, m1, spaced `WAIT_CYC+2` cycles apart. With `BUS_ARB_FIXED_PRIO_EN` defined: only m0 acks.
- Reset asserted during ACCESS of a write. Required: no ack; all outputs at reset values the next cycle; a new m0 request afterwards completes normally.
- Back-to-back m0 reads with req held through ack. Required: the second access starts in the IDLE after ACK, with its ack 3 cycles after the first (`WAIT_CYC=1`), and m0_rdata updates on each ack.
